// File: rtl/rv32i_multicycle_controller.sv
// RV32I multicycle control FSM: sequences fetch/decode/execute/writeback
// and decodes ALU operation, byte enables and immediate format.
module rv32i_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [3:0] MemWrite,
  output logic [2:0] ImmSrc,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_ILLEGAL  = 4'd14,
    S_UNUSED   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] A_PC  = 2'b00;
  localparam logic [1:0] A_OLD = 2'b01;
  localparam logic [1:0] A_REG = 2'b10;
  localparam logic [1:0] B_REG = 2'b00;
  localparam logic [1:0] B_IMM = 2'b01;
  localparam logic [1:0] B_4   = 2'b10;

  localparam logic [1:0] R_ALUOUT = 2'b00;
  localparam logic [1:0] R_DATA   = 2'b01;
  localparam logic [1:0] R_ALURES = 2'b10;

  state_t cur, nxt;

  logic       pcw, irw, rw, ret, ill;
  logic [3:0] mw;

  // funct7_5 only selects SUB for register-register ops
  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       f7,
    input logic       is_r
  );
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    ImmSrc = 3'b000;
    unique case (1'b1)
      op == OP_STORE: ImmSrc = 3'b001;
      op == OP_BR:    ImmSrc = 3'b010;
      op == OP_JAL:   ImmSrc = 3'b011;
      op == OP_LUI,
      op == OP_AUIPC: ImmSrc = 3'b100;
      default:        ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    nxt        = S_FETCH;
    pcw        = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    ret        = 1'b0;
    ill        = 1'b0;
    mw         = 4'b0000;
    AdrSrc     = 1'b0;
    ResultSrc  = R_ALUOUT;
    ALUSrcA    = A_PC;
    ALUSrcB    = B_REG;
    ALUControl = ALU_ADD;
    case (cur)
      S_FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcB   = B_4;
        ResultSrc = R_ALURES;
        nxt       = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = A_OLD;
        ALUSrcB = B_IMM;
        unique case (1'b1)
          op == OP_LOAD,
          op == OP_STORE: nxt = S_MEMADR;
          op == OP_R:     nxt = S_EXECR;
          op == OP_I:     nxt = S_EXECI;
          op == OP_BR:    nxt = S_BRANCH;
          op == OP_JAL:   nxt = S_JAL;
          op == OP_JALR:  nxt = S_JALR;
          op == OP_LUI:   nxt = S_LUI;
          op == OP_AUIPC: nxt = S_AUIPC;
          op == OP_FENCE,
          op == OP_SYS: begin
            ret = 1'b1;
            nxt = S_FETCH;
          end
          default:        nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = A_REG;
        ALUSrcB = B_IMM;
        nxt     = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        nxt    = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = R_DATA;
        rw        = 1'b1;
        ret       = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        ret    = 1'b1;
        case (funct3)
          3'b000:  mw = 4'b0001;
          3'b001:  mw = 4'b0011;
          3'b010:  mw = 4'b1111;
          default: mw = 4'b0000;
        endcase
      end
      S_EXECR: begin
        ALUSrcA    = A_REG;
        ALUSrcB    = B_REG;
        ALUControl = alu_dec(funct3, funct7_5, 1'b1);
        nxt        = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = A_REG;
        ALUSrcB    = B_IMM;
        ALUControl = alu_dec(funct3, funct7_5, 1'b0);
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        rw  = 1'b1;
        ret = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = A_REG;
        ALUSrcB = B_REG;
        ret     = 1'b1;
        // PC <= ALUOut (target computed in DECODE) only when taken
        case (funct3)
          3'b000: begin ALUControl = ALU_SUB;  pcw = zero;  end
          3'b001: begin ALUControl = ALU_SUB;  pcw = !zero; end
          3'b100: begin ALUControl = ALU_SLT;  pcw = !zero; end
          3'b101: begin ALUControl = ALU_SLT;  pcw = zero;  end
          3'b110: begin ALUControl = ALU_SLTU; pcw = !zero; end
          3'b111: begin ALUControl = ALU_SLTU; pcw = zero;  end
          default: begin ALUControl = ALU_SUB; pcw = 1'b0;  end
        endcase
      end
      S_JAL: begin
        ALUSrcA = A_OLD;
        ALUSrcB = B_4;
        pcw     = 1'b1;
        nxt     = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = A_REG;
        ALUSrcB = B_IMM;
        nxt     = S_JAL;
      end
      S_LUI: begin
        ALUSrcB    = B_IMM;
        ALUControl = ALU_PASSB;
        nxt        = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = A_OLD;
        ALUSrcB = B_IMM;
        nxt     = S_ALUWB;
      end
      S_ILLEGAL: begin
        ill = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // reset aborts any in-flight instruction without side effects
  assign PCWrite  = pcw & ~reset;
  assign IRWrite  = irw & ~reset;
  assign RegWrite = rw & ~reset;
  assign MemWrite = reset ? 4'b0000 : mw;
  assign retire   = ret & ~reset;
  assign illegal  = ill & ~reset;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Directed bench for rv32i_multicycle_controller: per-cycle vector
// table plus reset-abort and never-taken branch sequences.
module tb_rv32i_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl, MemWrite;
  logic [2:0] ImmSrc;
  logic [3:0] state;
  logic       retire, illegal;

  int checks = 0;
  int errors = 0;

  rv32i_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .MemWrite(MemWrite),
    .ImmSrc(ImmSrc), .state(state), .retire(retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu, mw;
    logic [2:0] imm;
    logic       ret, ill;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    exp_t       e;
  } vec_t;

  localparam int R = 7'b0110011, I = 7'b0010011, L = 7'b0000011;
  localparam int S = 7'b0100011, B = 7'b1100011, J = 7'b1101111;
  localparam int JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;
  localparam int FE = 7'b0001111, SY = 7'b1110011;

  vec_t tbl[$];

  function automatic exp_t mk(
    int st, int pcw, int adr, int irw, int rw, int rs, int sa,
    int sb, int alu, int mw, int imm, int ret, int ill
  );
    exp_t e;
    e.st = 4'(st); e.pcw = 1'(pcw); e.adr = 1'(adr);
    e.irw = 1'(irw); e.rw = 1'(rw); e.rs = 2'(rs);
    e.sa = 2'(sa); e.sb = 2'(sb); e.alu = 4'(alu);
    e.mw = 4'(mw); e.imm = 3'(imm); e.ret = 1'(ret);
    e.ill = 1'(ill);
    return e;
  endfunction

  task automatic row(int o, int f3, int f7, int z, exp_t e);
    vec_t v;
    v.op = 7'(o); v.f3 = 3'(f3); v.f7 = 1'(f7); v.z = 1'(z);
    v.e = e;
    tbl.push_back(v);
  endtask

  // FETCH then DECODE rows
  task automatic fd(int o, int f3, int f7, int z, int imm, int dret);
    row(o, f3, f7, z, mk(0, 1, 0, 1, 0, 2, 0, 2, 0, 0, imm, 0, 0));
    row(o, f3, f7, z, mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, imm, dret, 0));
  endtask

  task automatic wb(int o, int f3, int f7, int z, int imm);
    row(o, f3, f7, z, mk(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, imm, 1, 0));
  endtask

  task automatic alu_op(int o, int f3, int f7, int st, int sb, int alu);
    fd(o, f3, f7, 0, 0, 0);
    row(o, f3, f7, 0, mk(st, 0, 0, 0, 0, 0, 2, sb, alu, 0, 0, 0, 0));
    wb(o, f3, f7, 0, 0);
  endtask

  task automatic store(int f3, int mw);
    fd(S, f3, 0, 0, 1, 0);
    row(S, f3, 0, 0, mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0));
    row(S, f3, 0, 0, mk(5, 0, 1, 0, 0, 0, 0, 0, 0, mw, 1, 1, 0));
  endtask

  task automatic branch(int f3, int z, int alu, int pcw);
    fd(B, f3, 0, z, 2, 0);
    row(B, f3, 0, z, mk(9, pcw, 0, 0, 0, 0, 2, 0, alu, 0, 2, 1, 0));
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic drive(int o, int f3, int f7, int z);
    op = 7'(o); funct3 = 3'(f3); funct7_5 = 1'(f7); zero = 1'(z);
  endtask

  function automatic exp_t act_word();
    return {state, PCWrite, AdrSrc, IRWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl, MemWrite, ImmSrc,
            retire, illegal};
  endfunction

  initial begin
    exp_t a;

    alu_op(R, 0, 0, 6, 0, 4'b0000);
    alu_op(R, 0, 1, 6, 0, 4'b0001);
    alu_op(R, 5, 1, 6, 0, 4'b1001);
    alu_op(R, 6, 0, 6, 0, 4'b0011);
    alu_op(R, 7, 0, 6, 0, 4'b0010);
    alu_op(R, 2, 0, 6, 0, 4'b0101);
    alu_op(R, 4, 0, 6, 0, 4'b0100);
    alu_op(I, 0, 1, 7, 1, 4'b0000);
    alu_op(I, 3, 0, 7, 1, 4'b0110);
    alu_op(I, 5, 0, 7, 1, 4'b1000);
    alu_op(I, 1, 0, 7, 1, 4'b0111);
    fd(FE, 0, 0, 0, 0, 1);
    fd(SY, 0, 0, 0, 0, 1);
    fd(0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    fd(L, 2, 0, 0, 0, 0);
    row(L, 2, 0, 0, mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    row(L, 2, 0, 0, mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    row(L, 2, 0, 0, mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    store(1, 4'b0011);
    store(0, 4'b0001);
    store(2, 4'b1111);
    store(3, 4'b0000);
    branch(1, 0, 4'b0001, 1);
    branch(5, 0, 4'b0101, 0);
    branch(0, 1, 4'b0001, 1);
    branch(0, 0, 4'b0001, 0);
    branch(4, 0, 4'b0101, 1);
    branch(6, 1, 4'b0110, 0);
    branch(7, 1, 4'b0110, 1);
    fd(J, 0, 0, 0, 3, 0);
    row(J, 0, 0, 0, mk(10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 3, 0, 0));
    wb(J, 0, 0, 0, 3);
    fd(JR, 0, 0, 0, 0, 0);
    row(JR, 0, 0, 0, mk(11, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    row(JR, 0, 0, 0, mk(10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    wb(JR, 0, 0, 0, 0);
    fd(LU, 0, 0, 0, 4, 0);
    row(LU, 0, 0, 0, mk(12, 0, 0, 0, 0, 0, 0, 1, 4'b1010, 0, 4, 0, 0));
    wb(LU, 0, 0, 0, 4);
    fd(AU, 0, 0, 0, 4, 0);
    row(AU, 0, 0, 0, mk(13, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4, 0, 0));
    wb(AU, 0, 0, 0, 4);

    reset = 1'b1;
    drive(L, 2, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_irw", 32'(IRWrite), 0);
    chk("rst_pcw", 32'(PCWrite), 0);
    chk("rst_ret", 32'(retire), 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(int'(tbl[i].op), int'(tbl[i].f3), int'(tbl[i].f7),
            int'(tbl[i].z));
      #1;
      a = act_word();
      checks++;
      if (a !== tbl[i].e) begin
        errors++;
        $display("FAIL vec%0d: got %h want %h", i, a, tbl[i].e);
      end
      @(negedge clk);
    end

    // load aborted by a 1-cycle reset in MEMREAD
    drive(L, 2, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abt_ld_state", 32'(state), 3);
    reset = 1'b1;
    #1;
    chk("abt_ld_rw", 32'(RegWrite), 0);
    chk("abt_ld_mw", 32'(MemWrite), 0);
    chk("abt_ld_pcw", 32'(PCWrite), 0);
    chk("abt_ld_adr", 32'(AdrSrc), 1);
    @(negedge clk);
    #1;
    chk("abt_ld_fetch", 32'(state), 0);
    chk("abt_ld_irw_rst", 32'(IRWrite), 0);
    reset = 1'b0;
    #1;
    chk("abt_ld_irw", 32'(IRWrite), 1);
    @(negedge clk);
    #1;
    chk("abt_ld_next", 32'(state), 1);
    chk("abt_ld_rw2", 32'(RegWrite), 0);

    // store aborted in MEMWRITE
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(S, 2, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abt_st_state", 32'(state), 5);
    chk("abt_st_mw", 32'(MemWrite), 4'b1111);
    reset = 1'b1;
    #1;
    chk("abt_st_mw_rst", 32'(MemWrite), 0);
    chk("abt_st_ret_rst", 32'(retire), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abt_st_fetch", 32'(state), 0);

    // funct3 010/011 branches are never taken
    drive(B, 2, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("br010_state", 32'(state), 9);
    chk("br010_pcw", 32'(PCWrite), 0);
    chk("br010_ret", 32'(retire), 1);
    @(negedge clk);
    drive(B, 3, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("br011_state", 32'(state), 9);
    chk("br011_pcw", 32'(PCWrite), 0);
    zero = 1'b1;
    #1;
    chk("br011_pcw_z", 32'(PCWrite), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
